// File: rtl/scd_pkg.sv
// Shared definitions for the fetch/decode slice: opcode map, instruction field
// positions and the fetch FSM state type.
package scd_pkg;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_OR  = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4;
   localparam logic [3:0] OP_SHL = 4'h5;
   localparam logic [3:0] OP_SHR = 4'h6;
   localparam logic [3:0] OP_CMP = 4'h7;
   localparam logic [3:0] OP_LD  = 4'h8;
   localparam logic [3:0] OP_ST  = 4'h9;
   localparam logic [3:0] OP_JMP = 4'hA;
   localparam logic [3:0] OP_JZ  = 4'hB;
   localparam logic [3:0] OP_SPC = 4'hC;
   localparam logic [3:0] OP_WPC = 4'hD;
   localparam logic [3:0] OP_MOV = 4'hE;
   localparam logic [3:0] OP_LDI = 4'hF;

   // Fixed 16-bit instruction layout
   localparam int OPC_HI = 15;
   localparam int OPC_LO = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 8;
   localparam int RA_HI  = 7;
   localparam int RA_LO  = 4;
   localparam int RB_HI  = 3;
   localparam int RB_LO  = 0;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues imem requests, latches words into the IR and
// handles control-path redirects without ever abandoning an outstanding request.
module instr_fetch
   import scd_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter int              INSTR_W  = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               ir_valid,
   input  logic               ir_ready,
   output logic [3:0]         ir_opcode,
   output logic [3:0]         ir_rd,
   output logic [3:0]         ir_ra,
   output logic [3:0]         ir_rb,
   output logic [7:0]         ir_imm,
   output logic [PC_W-1:0]    ir_pc,
   output logic [PC_W-1:0]    link_pc,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc
);

   fetch_state_t       state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [PC_W-1:0]    drain_addr_q, drain_addr_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [PC_W-1:0]    ir_pc_q, ir_pc_d;
   logic               ir_valid_q, ir_valid_d;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      ir_d         = ir_q;
      ir_pc_d      = ir_pc_q;
      ir_valid_d   = ir_valid_q;
      case (state_q)
         FETCH: begin
            if (redirect) begin
               pc_d       = redirect_pc;
               ir_valid_d = 1'b0;
               // Unanswered request must still be completed at its old address
               if (!imem_ack) begin
                  state_d      = DRAIN;
                  drain_addr_d = pc_q;
               end
            end else if (imem_ack) begin
               ir_d       = imem_rdata;
               ir_pc_d    = pc_q;
               pc_d       = pc_q + 1'b1;
               ir_valid_d = 1'b1;
               state_d    = HOLD;
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_d       = redirect_pc;
               ir_valid_d = 1'b0;
               state_d    = FETCH;
            end else if (ir_ready) begin
               ir_valid_d = 1'b0;
               state_d    = FETCH;
            end
         end
         DRAIN: begin
            if (redirect) pc_d = redirect_pc;
            if (imem_ack) state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         drain_addr_q <= '0;
         ir_q         <= '0;
         ir_pc_q      <= '0;
         ir_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         ir_q         <= ir_d;
         ir_pc_q      <= ir_pc_d;
         ir_valid_q   <= ir_valid_d;
      end
   end

   // Request is suppressed while reset is held so a pending transaction is dropped
   assign imem_req  = rst_n & (state_q != HOLD);
   assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

   assign ir_valid  = ir_valid_q;
   assign ir_opcode = ir_q[OPC_HI:OPC_LO];
   assign ir_rd     = ir_q[RD_HI:RD_LO];
   assign ir_ra     = ir_q[RA_HI:RA_LO];
   assign ir_rb     = ir_q[RB_HI:RB_LO];
   assign ir_imm    = ir_q[IMM_HI:IMM_LO];
   assign ir_pc     = ir_pc_q;
   assign link_pc   = ir_pc_q + 1'b1;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: transaction-level model of the fetch rules plus a
// latency-programmable instruction memory, directed scenarios then random traffic.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n, imem_req, imem_ack, ir_valid, ir_ready, redirect;
   logic [7:0]  imem_addr, ir_pc, link_pc, redirect_pc, ir_imm;
   logic [15:0] imem_rdata;
   logic [3:0]  ir_opcode, ir_rd, ir_ra, ir_rb;

   instr_fetch #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir_valid(ir_valid),
      .ir_ready(ir_ready), .ir_opcode(ir_opcode), .ir_rd(ir_rd), .ir_ra(ir_ra),
      .ir_rb(ir_rb), .ir_imm(ir_imm), .ir_pc(ir_pc), .link_pc(link_pc),
      .redirect(redirect), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [15:0] mem [256];
   int          lat, lat_mode, wcnt;
   logic        stray;

   // Model: a request is either pending (wanted or junk) or the IR is held
   logic        m_pending = 1'b0, m_junk = 1'b0, m_valid = 1'b0;
   logic [7:0]  m_pc = 8'h00, m_addr = 8'h00, m_irpc = 8'h00;
   logic [15:0] m_ir = 16'h0000;

   logic        exp_req, obs_req;
   logic [7:0]  exp_addr, obs_addr;

   task automatic step();
      logic m_req;
      m_req    = rst_n && m_pending;
      exp_req  = m_req;
      exp_addr = m_addr;
      imem_ack   = m_req ? (wcnt >= lat) : stray;
      imem_rdata = (imem_ack && m_req) ? mem[m_addr] : 16'($urandom);
      #1;
      obs_req  = imem_req;
      obs_addr = imem_addr;
      if (!rst_n) begin
         m_pc = 8'h00; m_pending = 1'b1; m_junk = 1'b0;
         m_ir = 16'h0; m_irpc = 8'h00; m_valid = 1'b0;
      end else if (m_pending) begin
         if (imem_ack) begin
            if (!m_junk && !redirect) begin
               m_ir = imem_rdata; m_irpc = m_pc; m_pc = m_pc + 8'd1;
               m_valid = 1'b1; m_pending = 1'b0;
            end else begin
               if (redirect) m_pc = redirect_pc;
               m_valid = 1'b0; m_junk = 1'b0;
            end
         end else if (redirect) begin
            m_pc = redirect_pc; m_valid = 1'b0; m_junk = 1'b1;
         end
      end else if (redirect) begin
         m_pc = redirect_pc; m_valid = 1'b0; m_pending = 1'b1;
      end else if (ir_ready) begin
         m_valid = 1'b0; m_pending = 1'b1;
      end
      if (!m_junk) m_addr = m_pc;
      if (m_req) begin
         if (imem_ack) begin
            wcnt = 0;
            lat  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
         end else wcnt++;
      end else wcnt = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ir_ready = 1'b1; redirect = 1'b0; redirect_pc = 8'h00;
      stray = 1'b0; lat_mode = 0; lat = 0; wcnt = 0;
      step();
      total++; if (obs_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", obs_req); end
      total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", ir_valid); end
   endtask

   task automatic test_zero_wait();
      logic [15:0] w;
      rst_n = 1'b1;
      step();
      w = mem[0];
      total++; if (obs_req !== 1'b1 || obs_addr !== 8'h00) begin bad++; $display("FAIL zw_first_req got=%b/%h want=1/00", obs_req, obs_addr); end
      total++; if (ir_valid !== 1'b1 || ir_pc !== 8'h00 || ir_opcode !== w[15:12] || ir_imm !== w[7:0]) begin
         bad++; $display("FAIL zw_ir0 got=%b/%h/%h/%h want=1/00/%h/%h", ir_valid, ir_pc, ir_opcode, ir_imm, w[15:12], w[7:0]); end
      step();
      total++; if (obs_req !== 1'b0 || ir_valid !== 1'b0) begin bad++; $display("FAIL zw_gap got=%b/%b want=0/0", obs_req, ir_valid); end
      step();
      total++; if (obs_req !== 1'b1 || obs_addr !== 8'h01 || ir_pc !== 8'h01) begin bad++; $display("FAIL zw_second got=%b/%h/%h want=1/01/01", obs_req, obs_addr, ir_pc); end
      step(); step();
      total++; if (obs_req !== 1'b1 || obs_addr !== 8'h02) begin bad++; $display("FAIL zw_third got=%b/%h want=1/02", obs_req, obs_addr); end
   endtask

   task automatic test_delayed_ack();
      rst_n = 1'b0; ir_ready = 1'b0; lat_mode = 3; lat = 3; mem[0] = 16'hC412;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (obs_req !== 1'b1 || obs_addr !== 8'h00 || ir_valid !== 1'b0) begin
            bad++; $display("FAIL dly_hold%0d got=%b/%h/%b want=1/00/0", i, obs_req, obs_addr, ir_valid); end
      end
      step();
      total++; if (ir_valid !== 1'b1 || ir_opcode !== 4'hC || ir_rd !== 4'h4 || ir_ra !== 4'h1 || ir_rb !== 4'h2 || ir_imm !== 8'h12) begin
         bad++; $display("FAIL dly_fields got=%b/%h/%h/%h/%h/%h want=1/c/4/1/2/12", ir_valid, ir_opcode, ir_rd, ir_ra, ir_rb, ir_imm); end
      total++; if (ir_pc !== 8'h00 || link_pc !== 8'h01) begin bad++; $display("FAIL dly_pc got=%h/%h want=00/01", ir_pc, link_pc); end
   endtask

   task automatic test_redirect_hold();
      redirect = 1'b1; redirect_pc = 8'h40; lat_mode = 0; lat = 0;
      step();
      redirect = 1'b0;
      total++; if (ir_valid !== 1'b0 || obs_req !== 1'b0) begin bad++; $display("FAIL rh_flush got=%b/%b want=0/0", ir_valid, obs_req); end
      step();
      total++; if (obs_req !== 1'b1 || obs_addr !== 8'h40 || ir_valid !== 1'b1 || ir_pc !== 8'h40) begin
         bad++; $display("FAIL rh_target got=%b/%h/%b/%h want=1/40/1/40", obs_req, obs_addr, ir_valid, ir_pc); end
   endtask

   task automatic test_redirect_fetch();
      logic [15:0] w;
      ir_ready = 1'b1;
      step();
      ir_ready = 1'b0; lat = 2; redirect = 1'b1; redirect_pc = 8'h80;
      step();
      redirect = 1'b0;
      total++; if (obs_addr !== 8'h41 || ir_valid !== 1'b0) begin bad++; $display("FAIL rf_issue got=%h/%b want=41/0", obs_addr, ir_valid); end
      step();
      total++; if (obs_req !== 1'b1 || obs_addr !== 8'h41) begin bad++; $display("FAIL rf_drain got=%b/%h want=1/41", obs_req, obs_addr); end
      step();
      total++; if (obs_addr !== 8'h41 || ir_valid !== 1'b0) begin bad++; $display("FAIL rf_discard got=%h/%b want=41/0", obs_addr, ir_valid); end
      step();
      w = mem[8'h80];
      total++; if (obs_addr !== 8'h80 || ir_valid !== 1'b1 || ir_pc !== 8'h80 || ir_rd !== w[11:8]) begin
         bad++; $display("FAIL rf_target got=%h/%b/%h/%h want=80/1/80/%h", obs_addr, ir_valid, ir_pc, ir_rd, w[11:8]); end
   endtask

   task automatic test_wrap();
      ir_ready = 1'b1;
      step();
      ir_ready = 1'b0; redirect = 1'b1; redirect_pc = 8'hFF;
      step();
      redirect = 1'b0;
      total++; if (obs_addr !== 8'h81 || ir_valid !== 1'b0) begin bad++; $display("FAIL wr_drop got=%h/%b want=81/0", obs_addr, ir_valid); end
      step();
      total++; if (obs_addr !== 8'hFF || ir_valid !== 1'b1 || ir_pc !== 8'hFF || link_pc !== 8'h00) begin
         bad++; $display("FAIL wr_link got=%h/%b/%h/%h want=ff/1/ff/00", obs_addr, ir_valid, ir_pc, link_pc); end
      ir_ready = 1'b1;
      step();
      ir_ready = 1'b0; lat_mode = 5; lat = 5;
      step();
      total++; if (obs_req !== 1'b1 || obs_addr !== 8'h00) begin bad++; $display("FAIL wr_next got=%b/%h want=1/00", obs_req, obs_addr); end
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0; stray = 1'b1;
      step();
      total++; if (obs_req !== 1'b0 || ir_valid !== 1'b0) begin bad++; $display("FAIL rm_drop got=%b/%b want=0/0", obs_req, ir_valid); end
      rst_n = 1'b1; stray = 1'b0; lat_mode = 2; lat = 2;
      step();
      total++; if (obs_req !== 1'b1 || obs_addr !== 8'h00 || ir_valid !== 1'b0) begin
         bad++; $display("FAIL rm_restart got=%b/%h/%b want=1/00/0", obs_req, obs_addr, ir_valid); end
      step();
      total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL rm_late_ack got=%b want=0", ir_valid); end
   endtask

   task automatic test_random();
      lat_mode = -1;
      for (int n = 0; n < 800; n++) begin
         rst_n       = ($urandom_range(0, 99) >= 2);
         ir_ready    = $urandom_range(0, 1) == 1;
         redirect    = ($urandom_range(0, 9) == 0);
         redirect_pc = 8'($urandom);
         stray       = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 19) == 0) mem[$urandom_range(0, 255)] = 16'($urandom);
         step();
         total++; if (obs_req !== exp_req || (exp_req && obs_addr !== exp_addr)) begin
            bad++; $display("FAIL rnd_req[%0d] got=%b/%h want=%b/%h", n, obs_req, obs_addr, exp_req, exp_addr); end
         total++; if (ir_valid !== m_valid) begin bad++; $display("FAIL rnd_valid[%0d] got=%b want=%b", n, ir_valid, m_valid); end
         if (m_valid) begin
            total++; if ({ir_opcode, ir_rd, ir_ra, ir_rb} !== m_ir || ir_imm !== m_ir[7:0] || ir_pc !== m_irpc || link_pc !== m_irpc + 8'd1) begin
               bad++; $display("FAIL rnd_ir[%0d] got=%h%h%h%h/%h/%h want=%h/%h", n, ir_opcode, ir_rd, ir_ra, ir_rb, ir_pc, link_pc, m_ir, m_irpc); end
         end
      end
   endtask

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
      rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0; ir_ready = 1'b0;
      redirect = 1'b0; redirect_pc = 8'h00; stray = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_zero_wait();
      test_delayed_ack();
      test_redirect_hold();
      test_redirect_fetch();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
